fetch_pc: RTL and testbench

FETCH_PC -- requirements
Module: fetch_pc

---
 rtl/fetch_pc_if.sv | 21 ++
 rtl/fetch_pc.sv | 144 ++++++++++++++
 tb/tb_fetch_pc.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pc_if.sv
// Instruction-memory read handshake between the fetch unit (master) and memory (slave).
// The request and its address stay up until the slave returns fetch_ack.
interface fetch_pc_if #(
    parameter int unsigned ADDR_W = 16
);
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_ack;

    modport master (
        output fetch_req,
        output fetch_addr,
        input  fetch_ack
    );

    modport slave (
        input  fetch_req,
        input  fetch_addr,
        output fetch_ack
    );
endinterface

// File: rtl/fetch_pc.sv
// Program counter and fetch sequencer: issues one outstanding read at a time and
// drains stale requests after a redirect or trap so that only live words are reported.
module fetch_pc #(
    parameter int unsigned       ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned       STEP     = 1,
    parameter logic [ADDR_W-1:0] TRAP_VEC = ADDR_W'(16'h0004)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_addr,
    input  logic              trap,
    fetch_pc_if.master        mem,
    output logic              inst_valid,
    output logic [ADDR_W-1:0] inst_pc,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] epc
);

    localparam logic [ADDR_W-1:0] STEP_V = ADDR_W'(STEP);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DRAIN
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_drain_addr;
    logic              r_inst_valid;
    logic [ADDR_W-1:0] r_inst_pc;
    logic [ADDR_W-1:0] r_epc;

    state_t            w_state_nxt;
    state_t            w_after_ack;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic [ADDR_W-1:0] w_drain_nxt;
    logic              w_valid_nxt;
    logic [ADDR_W-1:0] w_inst_pc_nxt;
    logic [ADDR_W-1:0] w_epc_nxt;
    logic              w_redir;
    logic [ADDR_W-1:0] w_target;

    // Trap outranks redirect; both share the same control-flow effects.
    assign w_redir     = trap | redirect;
    assign w_target    = trap ? TRAP_VEC : redirect_addr;
    assign w_after_ack = hold ? ST_IDLE : ST_FETCH;

    // NOTE: every signal gets its default before the case so no path can leave
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_drain_nxt   = r_drain_addr;
        w_valid_nxt   = 1'b0;
        w_inst_pc_nxt = r_inst_pc;
        w_epc_nxt     = trap ? r_pc : r_epc;

        case (r_state)
            ST_IDLE: begin
                if (w_redir) begin
                    w_pc_nxt = w_target;
                end
                if (!hold) begin
                    w_state_nxt = ST_FETCH;
                end
            end

            ST_FETCH: begin
                if (mem.fetch_ack) begin
                    w_state_nxt = w_after_ack;
                    if (w_redir) begin
                        w_pc_nxt = w_target;
                    end else begin
                        w_valid_nxt   = 1'b1;
                        w_inst_pc_nxt = r_pc;
                        w_pc_nxt      = r_pc + STEP_V;
                    end
                end else if (w_redir) begin
                    w_drain_nxt = r_pc;
                    w_pc_nxt    = w_target;
                    w_state_nxt = ST_DRAIN;
                end
            end

            ST_DRAIN: begin
                // A stale word completing retires the drain even if a new
                // redirect arrives in the same cycle; the new target still lands.
                if (w_redir) begin
                    w_pc_nxt = w_target;
                end
                if (mem.fetch_ack) begin
                    w_state_nxt = w_after_ack;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_pc         <= RESET_PC;
            r_drain_addr <= '0;
            r_inst_valid <= 1'b0;
            r_inst_pc    <= '0;
            r_epc        <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_drain_addr <= w_drain_nxt;
            r_inst_valid <= w_valid_nxt;
            r_inst_pc    <= w_inst_pc_nxt;
            r_epc        <= w_epc_nxt;
        end
    end

    assign mem.fetch_req  = (r_state != ST_IDLE);
    assign mem.fetch_addr = (r_state == ST_DRAIN) ? r_drain_addr : r_pc;
    assign inst_valid     = r_inst_valid;
    assign inst_pc        = r_inst_pc;
    assign pc             = r_pc;
    assign epc            = r_epc;

    // An un-acked request must stay asserted with an unchanged address.
    a_req_held : assert property (
        @(posedge clk) disable iff (!rst)
        (mem.fetch_req && !mem.fetch_ack) |=> (mem.fetch_req && $stable(mem.fetch_addr))
    );

    a_valid_single : assert property (
        @(posedge clk) disable iff (!rst)
        inst_valid |-> $past(r_state == ST_FETCH && mem.fetch_ack)
    );

endmodule

// File: tb/tb_fetch_pc.sv
// Randomized scoreboard bench for fetch_pc: a request-level reference model predicts
// accepted words into a queue that an independent monitor drains against inst_valid.
module tb_fetch_pc;

    localparam logic [15:0] TRAP_VEC = 16'h0004;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        hold = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_addr = '0;
    logic        trap = 1'b0;
    logic        inst_valid;
    logic [15:0] inst_pc;
    logic [15:0] pc;
    logic [15:0] epc;

    fetch_pc_if #(.ADDR_W(16)) mem_if ();

    fetch_pc #(
        .ADDR_W  (16),
        .RESET_PC(16'h0000),
        .STEP    (1),
        .TRAP_VEC(TRAP_VEC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .hold         (hold),
        .redirect     (redirect),
        .redirect_addr(redirect_addr),
        .trap         (trap),
        .mem          (mem_if.master),
        .inst_valid   (inst_valid),
        .inst_pc      (inst_pc),
        .pc           (pc),
        .epc          (epc)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc++;

    typedef struct {
        logic [15:0] pc;
        int          due;
    } exp_t;

    exp_t sb_q[$];

    // Reference model: one read is either absent, live (will deliver a word) or dead.
    logic [15:0] m_pc, m_epc, m_req, m_inst;
    bit          m_out, m_dead;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_pc   = 16'h0000;
        m_epc  = 16'h0000;
        m_req  = 16'h0000;
        m_inst = 16'h0000;
        m_out  = 1'b0;
        m_dead = 1'b0;
        sb_q.delete();
    endtask

    task automatic model_step(input bit h, input bit r, input logic [15:0] ra,
                              input bit t, input bit a);
        bit          jump;
        logic [15:0] tgt;
        jump = r | t;
        tgt  = t ? TRAP_VEC : ra;
        if (t) m_epc = m_pc;
        if (!m_out) begin
            if (jump) m_pc = tgt;
            if (!h) begin
                m_out  = 1'b1;
                m_dead = 1'b0;
                m_req  = m_pc;
            end
        end else if (a) begin
            if (!m_dead && !jump) begin
                sb_q.push_back('{pc: m_req, due: cyc + 1});
                m_inst = m_req;
                m_pc   = m_req + 16'd1;
            end else if (jump) begin
                m_pc = tgt;
            end
            if (h) begin
                m_out = 1'b0;
            end else begin
                m_out  = 1'b1;
                m_dead = 1'b0;
                m_req  = m_pc;
            end
        end else if (jump) begin
            m_pc   = tgt;
            m_dead = 1'b1;
        end
    endtask

    task automatic check_outputs();
        check("fetch_req", {31'd0, mem_if.fetch_req}, {31'd0, m_out});
        check("fetch_addr", {16'd0, mem_if.fetch_addr}, {16'd0, m_out ? m_req : m_pc});
        check("pc", {16'd0, pc}, {16'd0, m_pc});
        check("epc", {16'd0, epc}, {16'd0, m_epc});
        check("inst_pc_hold", {16'd0, inst_pc}, {16'd0, m_inst});
    endtask

    task automatic cycle(input bit h, input bit r, input logic [15:0] ra,
                         input bit t, input bit a);
        hold              = h;
        redirect          = r;
        redirect_addr     = ra;
        trap              = t;
        mem_if.fetch_ack  = a;
        model_step(h, r, ra, t, a);
        @(negedge clk);
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        check("rst_fetch_req", {31'd0, mem_if.fetch_req}, 32'd0);
        check("rst_fetch_addr", {16'd0, mem_if.fetch_addr}, 32'd0);
        check("rst_pc", {16'd0, pc}, 32'd0);
        check("rst_epc", {16'd0, epc}, 32'd0);
        check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        check("rst_inst_pc", {16'd0, inst_pc}, 32'd0);
        model_reset();
        @(negedge clk);
        #1;
        rst = 1'b1;
    endtask

    // Monitor: consumes one predicted word per inst_valid pulse, flags extras and misses.
    always @(negedge clk) begin
        if (inst_valid) begin
            if (sb_q.size() == 0) begin
                check("inst_valid_unexpected", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("inst_pc_sb", {16'd0, inst_pc}, {16'd0, e.pc});
                check("inst_valid_cycle", cyc, e.due);
            end
        end else if (sb_q.size() != 0 && sb_q[0].due <= cyc) begin
            check("inst_valid_missing", 32'd0, 32'd1);
            void'(sb_q.pop_front());
        end
    end

    initial begin
        mem_if.fetch_ack = 1'b0;
        do_reset();

        // Sequential fetch from reset.
        cycle(0, 0, 16'h0, 0, 0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 16'h0, 0, 1);
        check("seq_pc_end", {16'd0, pc}, 32'd4);
        cycle(0, 0, 16'h0, 0, 1);

        // Redirect while the read at 5 is outstanding.
        cycle(0, 1, 16'h0100, 0, 0);
        check("drain_addr_held", {16'd0, mem_if.fetch_addr}, 32'h5);
        cycle(0, 0, 16'h0, 0, 0);
        check("drain_addr_wait", {16'd0, mem_if.fetch_addr}, 32'h5);
        cycle(0, 0, 16'h0, 0, 1);
        check("after_drain_addr", {16'd0, mem_if.fetch_addr}, 32'h100);

        // Same-cycle ack and redirect squash the word.
        cycle(0, 1, 16'h0007, 0, 1);
        cycle(0, 1, 16'h0020, 0, 1);
        check("squash_next_addr", {16'd0, mem_if.fetch_addr}, 32'h20);

        // Trap beats redirect.
        cycle(0, 1, 16'h0009, 0, 1);
        cycle(0, 1, 16'h0055, 1, 0);
        check("trap_pc", {16'd0, pc}, {16'd0, TRAP_VEC});
        check("trap_epc", {16'd0, epc}, 32'h9);
        cycle(0, 0, 16'h0, 0, 1);

        // Wrap at all-ones while stalled.
        cycle(0, 1, 16'hFFFF, 0, 1);
        cycle(1, 0, 16'h0, 0, 1);
        check("wrap_inst_valid", {31'd0, inst_valid}, 32'd1);
        check("wrap_inst_pc", {16'd0, inst_pc}, 32'hFFFF);
        check("wrap_pc", {16'd0, pc}, 32'd0);
        check("wrap_idle_req", {31'd0, mem_if.fetch_req}, 32'd0);
        cycle(1, 0, 16'h0, 0, 0);
        check("hold_idle_req", {31'd0, mem_if.fetch_req}, 32'd0);
        cycle(0, 0, 16'h0, 0, 0);
        check("resume_req", {31'd0, mem_if.fetch_req}, 32'd1);

        // Reset while a read at 0x30 is outstanding; the late ack must be ignored.
        cycle(0, 1, 16'h0030, 0, 1);
        check("pre_reset_addr", {16'd0, mem_if.fetch_addr}, 32'h30);
        do_reset();
        cycle(1, 0, 16'h0, 0, 1);
        check("late_ack_ignored", {31'd0, inst_valid}, 32'd0);
        cycle(0, 0, 16'h0, 0, 0);

        // Randomized traffic, biased toward boundaries and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            bit          h, r, t, a;
            logic [15:0] ra;
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                h  = ($urandom_range(0, 3) == 0);
                r  = ($urandom_range(0, 5) == 0);
                t  = ($urandom_range(0, 14) == 0);
                a  = ($urandom_range(0, 1) == 1);
                ra = ($urandom_range(0, 7) == 0) ? 16'hFFFF - 16'($urandom_range(0, 1))
                                                 : 16'($urandom);
                cycle(h, r, ra, t, a);
            end
        end

        hold             = 1'b1;
        redirect         = 1'b0;
        trap             = 1'b0;
        mem_if.fetch_ack = 1'b0;
        @(negedge clk);
        #1;
        check("sb_empty", sb_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
